// File: rtl/keycode_cmd_gen.sv
// keycode_cmd_gen: turns the packed HID keycode word into one-cycle game command
// pulses once per video frame, with delayed auto-shift and auto-repeat.
module keycode_cmd_gen #(
  parameter logic [7:0] KEY_LEFT    = 8'h04,
  parameter logic [7:0] KEY_RIGHT   = 8'h07,
  parameter logic [7:0] KEY_DOWN    = 8'h16,
  parameter logic [7:0] KEY_ROT     = 8'h1A,
  parameter logic [7:0] KEY_DROP    = 8'h2C,
  parameter int         DAS_FRAMES  = 10,
  parameter int         ARR_FRAMES  = 2,
  parameter int         SOFT_FRAMES = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        vsync,
  input  logic [31:0] keycode,
  output logic        frame_tick,
  output logic        cmd_left,
  output logic        cmd_right,
  output logic        cmd_down,
  output logic        cmd_rot,
  output logic        cmd_drop
);

  localparam int MAX_HA = (DAS_FRAMES > ARR_FRAMES) ? DAS_FRAMES : ARR_FRAMES;
  localparam int MAX_F  = (MAX_HA > SOFT_FRAMES) ? MAX_HA : SOFT_FRAMES;
  localparam int CW     = $clog2(MAX_F) + 1;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DAS_C   = CW'(DAS_FRAMES);
  localparam logic [CW-1:0] ARR_C   = CW'(ARR_FRAMES);
  localparam logic [CW-1:0] SOFT_C  = CW'(SOFT_FRAMES);

  typedef enum logic [1:0] {H_IDLE, H_DAS, H_ARR} h_state_t;

  function automatic logic key_held(input logic [31:0] kc, input logic [7:0] code);
    return (kc[31:24] == code) || (kc[23:16] == code) ||
           (kc[15:8]  == code) || (kc[7:0]   == code);
  endfunction

  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  h_state_t      h_state_q, h_state_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] soft_cnt_q, soft_cnt_d;
  logic          rot_prev_q, rot_prev_d, drop_prev_q, drop_prev_d;
  logic          left_q, left_d, right_q, right_d, down_q, down_d;
  logic          rot_q, rot_d, drop_q, drop_d;

  logic left_held, right_held, down_held, rot_held, drop_held;
  logic h_active, h_pulse;

  assign left_held  = key_held(keycode, KEY_LEFT);
  assign right_held = key_held(keycode, KEY_RIGHT);
  assign down_held  = key_held(keycode, KEY_DOWN);
  assign rot_held   = key_held(keycode, KEY_ROT);
  assign drop_held  = key_held(keycode, KEY_DROP);
  assign h_active   = left_held ^ right_held;

  assign frame_tick = s2_q & ~s3_q;

  always_comb begin
    s1_d        = vsync;
    s2_d        = s1_q;
    s3_d        = s2_q;
    h_state_d   = h_state_q;
    dir_d       = dir_q;
    h_cnt_d     = h_cnt_q;
    soft_cnt_d  = soft_cnt_q;
    rot_prev_d  = rot_prev_q;
    drop_prev_d = drop_prev_q;
    h_pulse     = 1'b0;
    left_d      = 1'b0;
    right_d     = 1'b0;
    down_d      = 1'b0;
    rot_d       = 1'b0;
    drop_d      = 1'b0;

    if (frame_tick) begin
      rot_d       = rot_held & ~rot_prev_q;
      drop_d      = drop_held & ~drop_prev_q;
      rot_prev_d  = rot_held;
      drop_prev_d = drop_held;

      // A zero soft counter marks a fresh press, so it pulses immediately.
      if (down_held) begin
        if (soft_cnt_q == '0 || soft_cnt_q == SOFT_C) begin
          down_d     = 1'b1;
          soft_cnt_d = CNT_ONE;
        end else begin
          soft_cnt_d = soft_cnt_q + CNT_ONE;
        end
      end else begin
        soft_cnt_d = '0;
      end

      if (!h_active) begin
        h_state_d = H_IDLE;
        h_cnt_d   = '0;
      end else if (h_state_q == H_IDLE || right_held != dir_q) begin
        h_pulse   = 1'b1;
        dir_d     = right_held;
        h_cnt_d   = CNT_ONE;
        h_state_d = H_DAS;
      end else if (h_state_q == H_DAS) begin
        if (h_cnt_q == DAS_C) begin
          h_pulse   = 1'b1;
          h_cnt_d   = CNT_ONE;
          h_state_d = H_ARR;
        end else begin
          h_cnt_d = h_cnt_q + CNT_ONE;
        end
      end else begin
        if (h_cnt_q == ARR_C) begin
          h_pulse   = 1'b1;
          h_cnt_d   = CNT_ONE;
          h_state_d = H_ARR;
        end else begin
          h_cnt_d = h_cnt_q + CNT_ONE;
        end
      end

      left_d  = h_pulse & ~right_held;
      right_d = h_pulse & right_held;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      h_state_q   <= H_IDLE;
      dir_q       <= 1'b0;
      h_cnt_q     <= '0;
      soft_cnt_q  <= '0;
      rot_prev_q  <= 1'b0;
      drop_prev_q <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      down_q      <= 1'b0;
      rot_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      h_state_q   <= h_state_d;
      dir_q       <= dir_d;
      h_cnt_q     <= h_cnt_d;
      soft_cnt_q  <= soft_cnt_d;
      rot_prev_q  <= rot_prev_d;
      drop_prev_q <= drop_prev_d;
      left_q      <= left_d;
      right_q     <= right_d;
      down_q      <= down_d;
      rot_q       <= rot_d;
      drop_q      <= drop_d;
    end
  end

  assign cmd_left  = left_q;
  assign cmd_right = right_q;
  assign cmd_down  = down_q;
  assign cmd_rot   = rot_q;
  assign cmd_drop  = drop_q;

endmodule

// File: tb/tb_keycode_cmd_gen.sv
// tb_keycode_cmd_gen: frame-level segments with hand-derived pulse counts, plus a
// per-cycle scoreboard fed by a behavioural model of the command timing.
module tb_keycode_cmd_gen;

  localparam int DAS  = 10;
  localparam int ARR  = 2;
  localparam int SOFT = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        vsync;
  logic [31:0] keycode;
  logic        frame_tick, cmd_left, cmd_right, cmd_down, cmd_rot, cmd_drop;

  always #5 Clk = ~Clk;

  keycode_cmd_gen #(
    .DAS_FRAMES(DAS), .ARR_FRAMES(ARR), .SOFT_FRAMES(SOFT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .vsync(vsync), .keycode(keycode),
    .frame_tick(frame_tick), .cmd_left(cmd_left), .cmd_right(cmd_right),
    .cmd_down(cmd_down), .cmd_rot(cmd_rot), .cmd_drop(cmd_drop)
  );

  typedef struct {
    int         at;
    logic [4:0] cmds;
  } exp_t;

  typedef struct {
    logic [31:0] key;
    int          frames;
    int          exp_l, exp_r, exp_d, exp_rot, exp_drop;
  } seg_t;

  exp_t sb[$];
  seg_t segs[20];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int obs_l = 0, obs_r = 0, obs_d = 0, obs_rot = 0, obs_drop = 0;

  int   h_run = -1;
  logic h_dir = 1'b0;
  int   d_run = -1;
  logic rot_prev = 1'b0, drop_prev = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic has_key(input logic [31:0] k, input logic [7:0] code);
    logic [31:0] kv;
    kv = k;
    for (int b = 0; b < 4; b++)
      if (kv[b*8 +: 8] == code) return 1'b1;
    return 1'b0;
  endfunction

  // Horizontal timing is modelled as a run length since the press began.
  function automatic logic [4:0] model_step(input logic [31:0] k);
    logic l, r, d, ro, dr;
    logic pl = 1'b0, pr = 1'b0, pd = 1'b0;
    logic [4:0] res;
    l  = has_key(k, 8'h04);
    r  = has_key(k, 8'h07);
    d  = has_key(k, 8'h16);
    ro = has_key(k, 8'h1A);
    dr = has_key(k, 8'h2C);
    if (l ^ r) begin
      if (h_run < 0 || r != h_dir) begin
        h_run = 0;
        h_dir = r;
      end else begin
        h_run++;
      end
      if (h_run == 0 || h_run == DAS || (h_run > DAS && (h_run - DAS) % ARR == 0)) begin
        pl = ~r;
        pr = r;
      end
    end else begin
      h_run = -1;
    end
    if (d) begin
      d_run++;
      pd = ((d_run % SOFT) == 0);
    end else begin
      d_run = -1;
    end
    res = {pl, pr, pd, ro & ~rot_prev, dr & ~drop_prev};
    rot_prev  = ro;
    drop_prev = dr;
    return res;
  endfunction

  function automatic void model_reset();
    h_run     = -1;
    h_dir     = 1'b0;
    d_run     = -1;
    rot_prev  = 1'b0;
    drop_prev = 1'b0;
  endfunction

  always @(negedge Clk) begin
    logic [4:0] exp_cmds;
    logic       exp_tick;
    exp_cmds = '0;
    exp_tick = (sb.size() > 0) && (sb[0].at == cyc + 1);
    if (sb.size() > 0 && sb[0].at == cyc) begin
      exp_cmds = sb[0].cmds;
      void'(sb.pop_front());
    end
    checkOutput("frame_tick", {31'd0, frame_tick}, {31'd0, exp_tick});
    checkOutput("cmds {L,R,D,rot,drop}",
                {27'd0, cmd_left, cmd_right, cmd_down, cmd_rot, cmd_drop}, {27'd0, exp_cmds});
    obs_l    += int'(cmd_left);
    obs_r    += int'(cmd_right);
    obs_d    += int'(cmd_down);
    obs_rot  += int'(cmd_rot);
    obs_drop += int'(cmd_drop);
  end

  // One frame: vsync high for 4 cycles then low for 4, starting on a falling edge.
  task automatic applyStimulus(input logic [31:0] key);
    keycode = key;
    vsync   = 1'b1;
    sb.push_back('{at: cyc + 3, cmds: model_step(key)});
    repeat (4) @(negedge Clk);
    vsync = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic run_segment(input int i);
    int l0 = obs_l, r0 = obs_r, d0 = obs_d, ro0 = obs_rot, dr0 = obs_drop;
    for (int f = 0; f < segs[i].frames; f++) applyStimulus(segs[i].key);
    checkOutput($sformatf("seg%0d left count", i),  obs_l - l0,     segs[i].exp_l);
    checkOutput($sformatf("seg%0d right count", i), obs_r - r0,     segs[i].exp_r);
    checkOutput($sformatf("seg%0d down count", i),  obs_d - d0,     segs[i].exp_d);
    checkOutput($sformatf("seg%0d rot count", i),   obs_rot - ro0,  segs[i].exp_rot);
    checkOutput($sformatf("seg%0d drop count", i),  obs_drop - dr0, segs[i].exp_drop);
  endtask

  initial begin
    logic [4:0] exp_pre;

    segs[0]  = '{32'h0000_0004,  1, 1, 0, 0, 0, 0};
    segs[1]  = '{32'h0000_0000,  1, 0, 0, 0, 0, 0};
    segs[2]  = '{32'h0000_0700, 20, 0, 6, 0, 0, 0};
    segs[3]  = '{32'h0000_0000,  1, 0, 0, 0, 0, 0};
    segs[4]  = '{32'h0000_0704,  5, 0, 0, 0, 0, 0};
    segs[5]  = '{32'h0000_0004, 11, 2, 0, 0, 0, 0};
    segs[6]  = '{32'h0000_0000,  1, 0, 0, 0, 0, 0};
    segs[7]  = '{32'h0000_0004,  4, 1, 0, 0, 0, 0};
    segs[8]  = '{32'h0000_0007, 11, 0, 2, 0, 0, 0};
    segs[9]  = '{32'h0000_0000,  1, 0, 0, 0, 0, 0};
    segs[10] = '{32'h0000_2C1A,  8, 0, 0, 0, 1, 1};
    segs[11] = '{32'h0000_0000,  2, 0, 0, 0, 0, 0};
    segs[12] = '{32'h2C1A_0000,  3, 0, 0, 0, 1, 1};
    segs[13] = '{32'h0000_0000,  1, 0, 0, 0, 0, 0};
    segs[14] = '{32'h0016_0000,  7, 0, 0, 3, 0, 0};
    segs[15] = '{32'h0000_0000,  1, 0, 0, 0, 0, 0};
    segs[16] = '{32'h1A16_0400,  4, 1, 0, 2, 1, 0};
    segs[17] = '{32'h0000_0000,  1, 0, 0, 0, 0, 0};
    segs[18] = '{32'h0000_0004, 12, 2, 0, 0, 0, 0};
    segs[19] = '{32'h0000_0004, 11, 2, 0, 0, 0, 0};

    Reset   = 1'b1;
    vsync   = 1'b1;
    keycode = 32'h0000_0004;
    repeat (3) @(negedge Clk);
    checkOutput("outputs during reset",
                {26'd0, frame_tick, cmd_left, cmd_right, cmd_down, cmd_rot, cmd_drop}, 32'd0);
    vsync = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);

    for (int i = 0; i < 19; i++) run_segment(i);

    // Left has been held 12 frames, so this frame lands on an auto-repeat pulse.
    keycode = 32'h0000_0004;
    vsync   = 1'b1;
    exp_pre = model_step(keycode);
    sb.push_back('{at: cyc + 3, cmds: exp_pre});
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("left pulse before reset", {31'd0, cmd_left}, {31'd0, exp_pre[4]});
    Reset = 1'b1;
    vsync = 1'b0;
    sb.delete();
    model_reset();
    #1;
    checkOutput("async reset clears outputs",
                {26'd0, frame_tick, cmd_left, cmd_right, cmd_down, cmd_rot, cmd_drop}, 32'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    run_segment(19);
    applyStimulus(32'h0000_0000);
    repeat (4) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
